// File: rtl/seq_pkg.sv
// seq_pkg: shared types and defaults for the fetch/exec sequencer.
package seq_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam logic RW_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;
endpackage

// File: rtl/fetch_exec_sequencer_ram.sv
// simple_sp_ram: single-port RAM with synchronous write and registered read.
module simple_sp_ram #(
  parameter int DEPTH = 256,
  parameter int DATA_W = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    if (re) r_rdata <= r_mem[addr];
  end
  assign rdata = r_rdata;
endmodule

// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer: owns program/data RAM and steps the interpreter through FETCH/DECODE/EXEC.
module fetch_exec_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read_write_memory,
  input  logic [DATA_W-1:0] data_out_memory,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] inst,
  output logic              enable,
  output logic [DATA_W-1:0] data_in_memory,
  output logic              busy,
  output logic [15:0]       retired
);
  localparam int AW = $clog2(DEPTH);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] w_sel;
  logic [AW-1:0] w_ram_addr;
  logic w_ram_we, w_ram_re;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;
  logic [DATA_W-1:0] r_inst, r_din;
  logic [15:0] r_retired;
  // IDLE owns the port for program load; the data port serves DECODE reads and EXEC writes
  always_comb begin
    w_sel = r_state == IDLE ? prog_addr : r_state == FETCH ? PC : addr;
    w_ram_addr = AW'(w_sel % DEPTH);
    w_ram_we = (r_state == IDLE && prog_we) || (r_state == EXEC && read_write_memory == RW_WRITE);
    w_ram_re = r_state == FETCH || r_state == DECODE;
    w_ram_wdata = r_state == IDLE ? prog_data : data_out_memory;
    w_next = r_state == IDLE ? (run ? FETCH : IDLE) :
             r_state == FETCH ? DECODE :
             r_state == DECODE ? EXEC : (run ? FETCH : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_inst <= '0;
      r_din <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_inst <= w_ram_rdata;
      if (r_state == EXEC) begin
        r_din <= w_ram_rdata;
        r_retired <= r_retired + 16'd1;
      end
    end
  end
  simple_sp_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk(clk),
    .we(w_ram_we),
    .re(w_ram_re),
    .addr(w_ram_addr),
    .wdata(w_ram_wdata),
    .rdata(w_ram_rdata)
  );
  // the DECODE read lands in the RAM output register, so EXEC sees it live and r_din holds it afterwards
  assign data_in_memory = r_state == EXEC ? w_ram_rdata : r_din;
  assign inst = r_inst;
  assign enable = r_state == EXEC;
  assign busy = r_state != IDLE;
  assign retired = r_retired;
endmodule
